// File: rtl/residual_add.sv
// Element-serial residual adder: captures the residual tensor, adds streamed sublayer
// elements with signed saturation, and publishes the full sum tensor on completion.
module residual_add #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SEQ_LEN    = 8,
  parameter int unsigned EMB_DIM    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] residual_in,
  input  logic                                  sub_valid,
  output logic                                  sub_ready,
  input  logic [DATA_WIDTH-1:0]                 sub_data,
  output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] sum_out,
  output logic                                  out_valid,
  output logic                                  done,
  output logic                                  busy,
  output logic [15:0]                           sat_count
);

  localparam int unsigned NUM_ELEM = SEQ_LEN * EMB_DIM;
  localparam int unsigned IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] res_mem [NUM_ELEM];
  logic [DATA_WIDTH-1:0] sum_mem [NUM_ELEM];

  logic [DATA_WIDTH:0]   wide_sum_c;
  logic [DATA_WIDTH-1:0] sat_sum_c;
  logic                  clamp_c;

  assign sub_ready = (state == S_ACCUM);
  assign busy      = (state != S_IDLE);

  // 17-bit sign-extended add; the two top bits disagree exactly when the result overflows
  always_comb begin
    wide_sum_c = {res_mem[idx][DATA_WIDTH-1], res_mem[idx]}
               + {sub_data[DATA_WIDTH-1], sub_data};
    clamp_c    = (wide_sum_c[DATA_WIDTH] != wide_sum_c[DATA_WIDTH-1]);
    sat_sum_c  = wide_sum_c[DATA_WIDTH-1:0];
    if (clamp_c) begin
      sat_sum_c = wide_sum_c[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      sat_count <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      for (int unsigned i = 0; i < NUM_ELEM; i++) begin
        res_mem[i] <= '0;
        sum_mem[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_ELEM; i++) begin
              res_mem[i] <= residual_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            idx       <= '0;
            sat_count <= '0;
            state     <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (sub_valid) begin
            sum_mem[idx] <= sat_sum_c;
            if (clamp_c && (sat_count != 16'hFFFF)) begin
              sat_count <= sat_count + 16'd1;
            end
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          // whole-tensor publish so downstream never sees a partial result
          for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            sum_out[i*DATA_WIDTH +: DATA_WIDTH] <= sum_mem[i];
          end
          out_valid <= 1'b1;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_residual_add.sv
// Directed + randomized bench for residual_add against an integer-arithmetic reference.
module tb_residual_add;

  localparam int unsigned W = 16;
  localparam int unsigned S = 8;
  localparam int unsigned E = 8;
  localparam int unsigned N = S * E;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W*N-1:0]   residual_in = '0;
  logic             sub_valid = 1'b0;
  logic             sub_ready;
  logic [W-1:0]     sub_data = '0;
  logic [W*N-1:0]   sum_out;
  logic             out_valid;
  logic             done;
  logic             busy;
  logic [15:0]      sat_count;

  residual_add #(.DATA_WIDTH(W), .SEQ_LEN(S), .EMB_DIM(E)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .residual_in(residual_in),
    .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_data(sub_data),
    .sum_out(sum_out), .out_valid(out_valid), .done(done), .busy(busy),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  logic [15:0] res_q [N];
  logic [15:0] sub_q [N];
  logic [15:0] exp_q [N];
  int          exp_sat;
  int          t0;
  int          stalls;
  logic [W*N-1:0] prev_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer add, then clamp to the signed 16-bit range
  task automatic build_expected();
    exp_sat = 0;
    for (int k = 0; k < int'(N); k++) begin
      int s;
      s = int'($signed(res_q[k])) + int'($signed(sub_q[k]));
      if (s > 32767) begin
        exp_q[k] = 16'h7FFF;
        exp_sat++;
      end else if (s < -32768) begin
        exp_q[k] = 16'h8000;
        exp_sat++;
      end else begin
        exp_q[k] = 16'(s);
      end
    end
    if (exp_sat > 65535) exp_sat = 65535;
  endtask

  task automatic scramble_residual();
    for (int k = 0; k < int'(N); k++) residual_in[k*W +: W] = 16'($urandom);
  endtask

  task automatic start_tensor(input string tag);
    for (int k = 0; k < int'(N); k++) residual_in[k*W +: W] = res_q[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    scramble_residual();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(sub_ready), 32'd1);
  endtask

  // mode 0: no gaps, 1: one idle cycle before each element, 2: random 0..2 idle cycles
  task automatic stream(input int mode, input int mid_start, input int count);
    stalls = 0;
    for (int k = 0; k < count; k++) begin
      int gap;
      gap = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(2, 0)) : 0);
      for (int g = 0; g < gap; g++) begin
        sub_valid = 1'b0;
        sub_data  = 16'hDEAD;
        @(posedge clk); #1;
        stalls++;
      end
      sub_valid = 1'b1;
      sub_data  = sub_q[k];
      if (k == mid_start) begin
        start = 1'b1;
        scramble_residual();
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    sub_valid = 1'b0;
    sub_data  = 16'hDEAD;
  endtask

  task automatic finish_tensor(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - t0), 32'(int'(N) + 1 + stalls));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_sat_count"}, 32'(sat_count), 32'(exp_sat));
    for (int k = 0; k < int'(N); k++)
      chk($sformatf("%s_sum[%0d]", tag, k), 32'(sum_out[k*W +: W]), 32'(exp_q[k]));
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
  endtask

  task automatic fill_basic();
    for (int k = 0; k < int'(N); k++) begin
      res_q[k] = 16'(k);
      sub_q[k] = 16'd1;
    end
    build_expected();
  endtask

  task automatic fill_random();
    for (int k = 0; k < int'(N); k++) begin
      res_q[k] = 16'($urandom);
      sub_q[k] = 16'($urandom);
    end
    build_expected();
  endtask

  initial begin
    sub_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(sub_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sat", 32'(sat_count), 32'd0);
    chk("rst_sum_nonzero", 32'(|sum_out), 32'd0);
    rst_n = 1'b1;

    // sub_valid while idle must not be consumed
    sub_valid = 1'b1;
    sub_data  = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(sub_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    sub_valid = 1'b0;

    fill_basic();
    start_tensor("basic");
    stream(0, -1, int'(N));
    finish_tensor("basic");
    check_pulse_end("basic");

    for (int k = 0; k < int'(N); k++) begin
      res_q[k] = 16'd0;
      sub_q[k] = 16'd0;
    end
    res_q[0] = 16'h7FF0; sub_q[0] = 16'h0100;
    res_q[1] = 16'h8010; sub_q[1] = 16'hFF00;
    build_expected();
    start_tensor("sat");
    stream(0, -1, int'(N));
    finish_tensor("sat");
    check_pulse_end("sat");

    fill_basic();
    start_tensor("gaps");
    stream(1, -1, int'(N));
    finish_tensor("gaps");
    check_pulse_end("gaps");

    start_tensor("midstart");
    stream(0, 30, int'(N));
    finish_tensor("midstart");
    check_pulse_end("midstart");

    // reset in the middle of a random tensor
    fill_random();
    start_tensor("rstmid");
    stream(0, -1, 20);
    sub_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(sub_ready), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_ov", 32'(out_valid), 32'd0);
    chk("rstmid_sat", 32'(sat_count), 32'd0);
    chk("rstmid_sum_nonzero", 32'(|sum_out), 32'd0);
    sub_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_no_done", 32'(done), 32'd0);
    fill_basic();
    start_tensor("postrst");
    stream(0, -1, int'(N));
    finish_tensor("postrst");
    check_pulse_end("postrst");

    // back-to-back: second start in the idle cycle carrying the done pulse
    fill_random();
    start_tensor("b2b_a");
    stream(0, -1, int'(N));
    finish_tensor("b2b_a");
    prev_vec = sum_out;
    for (int k = 0; k < int'(N); k++) begin
      res_q[k] = 16'hFFFF;
      sub_q[k] = 16'd1;
    end
    build_expected();
    start_tensor("b2b_b");
    stream(0, -1, int'(N) - 1);
    chk("b2b_hold_mismatch", 32'(sum_out != prev_vec), 32'd0);
    chk("b2b_hold_ov", 32'(out_valid), 32'd0);
    sub_valid = 1'b1;
    sub_data  = sub_q[N-1];
    @(posedge clk); #1;
    sub_valid = 1'b0;
    stalls = 0;
    chk("b2b_hold_last", 32'(sum_out != prev_vec), 32'd0);
    finish_tensor("b2b_b");
    check_pulse_end("b2b_b");

    for (int t = 0; t < 3; t++) begin
      fill_random();
      start_tensor($sformatf("rand%0d", t));
      stream(2, -1, int'(N));
      finish_tensor($sformatf("rand%0d", t));
      check_pulse_end($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
